// File: rtl/fix_field_stream.sv
// Streaming FIX field extractor: splits a byte stream into tag=value<SOH> fields,
// captures watched tags per message and verifies the trailing 10= checksum.
module fix_field_stream #(
  parameter int         NUM_WATCH   = 4,
  parameter int         VALUE_BYTES = 32,
  parameter logic [7:0] SOH         = 8'h01,
  localparam int        LEN_W       = $clog2(VALUE_BYTES + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         data_i,
  input  logic                               data_valid_i,
  input  logic [NUM_WATCH*32-1:0]            watch_tag_i,
  input  logic [NUM_WATCH-1:0]               watch_en_i,
  output logic [31:0]                        field_tag_o,
  output logic [VALUE_BYTES*8-1:0]           field_value_o,
  output logic [LEN_W-1:0]                   field_len_o,
  output logic                               field_valid_o,
  output logic [NUM_WATCH*VALUE_BYTES*8-1:0] watch_value_o,
  output logic [NUM_WATCH-1:0]               watch_hit_o,
  output logic                               msg_done_o,
  output logic [7:0]                         checksum_o,
  output logic                               checksum_ok_o,
  output logic                               error_o,
  output logic [1:0]                         error_code_o
);

  typedef enum logic [1:0] {S_TAG, S_VALUE, S_SKIP} state_t;

  state_t                           r_state, w_state_nxt;
  logic [31:0]                      r_tag_acc;
  logic [3:0]                       r_tag_cnt;
  logic [VALUE_BYTES*8-1:0]         r_val;
  logic [LEN_W-1:0]                 r_len;
  logic [7:0]                       r_field_sum, r_msg_sum;
  logic                             r_new_msg;

  logic [31:0]                      r_field_tag;
  logic [VALUE_BYTES*8-1:0]         r_field_value;
  logic [LEN_W-1:0]                 r_field_len;
  logic                             r_field_valid;
  logic [NUM_WATCH*VALUE_BYTES*8-1:0] r_watch_val;
  logic [NUM_WATCH-1:0]             r_hit;
  logic                             r_msg_done;
  logic [7:0]                       r_checksum;
  logic                             r_checksum_ok;
  logic                             r_error;
  logic [1:0]                       r_error_code;

  logic       w_is_digit, w_is_soh, w_is_eq;
  logic       w_err, w_tag_shift, w_store, w_complete, w_field_end, w_tag_is_10;
  logic [1:0] w_err_code;
  logic [7:0] w_field_sum_nxt;
  logic [9:0] w_d0, w_d1, w_d2, w_rx_num;
  logic       w_rx_digits, w_ck_ok;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  assign w_is_digit      = is_digit(data_i);
  assign w_is_soh        = (data_i == SOH);
  assign w_is_eq         = (data_i == 8'h3D);
  assign w_field_end     = data_valid_i && w_is_soh;
  assign w_tag_is_10     = (r_tag_acc == 32'd10);
  assign w_field_sum_nxt = r_field_sum + data_i;

  // Received checksum is the first three stored value bytes read as decimal.
  assign w_d0        = {2'b00, r_val[7:0]   - 8'h30};
  assign w_d1        = {2'b00, r_val[15:8]  - 8'h30};
  assign w_d2        = {2'b00, r_val[23:16] - 8'h30};
  assign w_rx_num    = w_d0 * 10'd100 + w_d1 * 10'd10 + w_d2;
  assign w_rx_digits = is_digit(r_val[7:0]) && is_digit(r_val[15:8]) && is_digit(r_val[23:16]);
  assign w_ck_ok     = (r_len == LEN_W'(3)) && w_rx_digits && (w_rx_num == {2'b00, r_msg_sum});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_TAG;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_err_code  = 2'd0;
    w_tag_shift = 1'b0;
    w_store     = 1'b0;
    w_complete  = 1'b0;
    if (data_valid_i) begin
      case (r_state)
        S_TAG: begin
          if (w_is_soh) begin
            w_err      = 1'b1;
            w_err_code = 2'd1;
          end else if (w_is_digit && (r_tag_cnt != 4'd9)) begin
            w_tag_shift = 1'b1;
          end else if (w_is_eq && (r_tag_cnt != 4'd0)) begin
            w_state_nxt = S_VALUE;
          end else begin
            w_err       = 1'b1;
            w_err_code  = 2'd1;
            w_state_nxt = S_SKIP;
          end
        end
        S_VALUE: begin
          if (w_is_soh) begin
            w_complete  = 1'b1;
            w_state_nxt = S_TAG;
          end else if (r_len == LEN_W'(VALUE_BYTES)) begin
            w_err       = 1'b1;
            w_err_code  = 2'd2;
            w_state_nxt = S_SKIP;
          end else begin
            w_store = 1'b1;
          end
        end
        S_SKIP: if (w_is_soh) w_state_nxt = S_TAG;
        default: w_state_nxt = S_TAG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_acc     <= '0;
      r_tag_cnt     <= '0;
      r_val         <= '0;
      r_len         <= '0;
      r_field_sum   <= '0;
      r_msg_sum     <= '0;
      r_new_msg     <= 1'b1;
      r_field_tag   <= '0;
      r_field_value <= '0;
      r_field_len   <= '0;
      r_field_valid <= 1'b0;
      r_watch_val   <= '0;
      r_hit         <= '0;
      r_msg_done    <= 1'b0;
      r_checksum    <= '0;
      r_checksum_ok <= 1'b0;
      r_error       <= 1'b0;
      r_error_code  <= '0;
    end else begin
      r_field_valid <= 1'b0;
      r_msg_done    <= 1'b0;
      r_error       <= 1'b0;
      if (data_valid_i) begin
        if (r_new_msg) begin
          r_hit     <= '0;
          r_new_msg <= 1'b0;
        end
        if (w_err) begin
          r_error      <= 1'b1;
          r_error_code <= w_err_code;
        end
        if (w_tag_shift) begin
          r_tag_acc <= r_tag_acc * 32'd10 + {28'd0, data_i[3:0]};
          r_tag_cnt <= r_tag_cnt + 4'd1;
        end
        if (w_store) begin
          for (int i = 0; i < VALUE_BYTES; i++)
            if (r_len == LEN_W'(i)) r_val[i*8 +: 8] <= data_i;
          r_len <= r_len + LEN_W'(1);
        end
        // Any SOH closes the field, whatever state it arrives in.
        if (w_field_end) begin
          r_field_sum <= '0;
          r_tag_acc   <= '0;
          r_tag_cnt   <= '0;
          r_val       <= '0;
          r_len       <= '0;
          if (!w_tag_is_10) r_msg_sum <= r_msg_sum + w_field_sum_nxt;
        end else begin
          r_field_sum <= w_field_sum_nxt;
        end
        if (w_complete) begin
          r_field_valid <= 1'b1;
          r_field_tag   <= r_tag_acc;
          r_field_value <= r_val;
          r_field_len   <= r_len;
          for (int i = 0; i < NUM_WATCH; i++) begin
            if (watch_en_i[i] && (watch_tag_i[32*i +: 32] == r_tag_acc)) begin
              r_watch_val[i*VALUE_BYTES*8 +: VALUE_BYTES*8] <= r_val;
              r_hit[i] <= 1'b1;
            end
          end
          if (w_tag_is_10) begin
            r_msg_done    <= 1'b1;
            r_checksum    <= r_msg_sum;
            r_checksum_ok <= w_ck_ok;
            r_msg_sum     <= '0;
            r_new_msg     <= 1'b1;
          end
        end
      end
    end
  end

  assign field_tag_o   = r_field_tag;
  assign field_value_o = r_field_value;
  assign field_len_o   = r_field_len;
  assign field_valid_o = r_field_valid;
  assign watch_value_o = r_watch_val;
  assign watch_hit_o   = r_hit;
  assign msg_done_o    = r_msg_done;
  assign checksum_o    = r_checksum;
  assign checksum_ok_o = r_checksum_ok;
  assign error_o       = r_error;
  assign error_code_o  = r_error_code;

endmodule

// File: tb/tb_fix_field_stream.sv
// Bench for fix_field_stream: directed vector table, hand sequences for reset and
// gaps, and random messages checked against a field-level reference model.
module tb_fix_field_stream;
  localparam int NW = 4;
  localparam int VB = 4;
  localparam int LW = $clog2(VB + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        data_i;
  logic              data_valid_i;
  logic [NW*32-1:0]  watch_tag_i;
  logic [NW-1:0]     watch_en_i;
  logic [31:0]       field_tag_o;
  logic [VB*8-1:0]   field_value_o;
  logic [LW-1:0]     field_len_o;
  logic              field_valid_o;
  logic [NW*VB*8-1:0] watch_value_o;
  logic [NW-1:0]     watch_hit_o;
  logic              msg_done_o;
  logic [7:0]        checksum_o;
  logic              checksum_ok_o;
  logic              error_o;
  logic [1:0]        error_code_o;

  fix_field_stream #(.NUM_WATCH(NW), .VALUE_BYTES(VB), .SOH(8'h01)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
    .watch_tag_i(watch_tag_i), .watch_en_i(watch_en_i),
    .field_tag_o(field_tag_o), .field_value_o(field_value_o), .field_len_o(field_len_o),
    .field_valid_o(field_valid_o), .watch_value_o(watch_value_o), .watch_hit_o(watch_hit_o),
    .msg_done_o(msg_done_o), .checksum_o(checksum_o), .checksum_ok_o(checksum_ok_o),
    .error_o(error_o), .error_code_o(error_code_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int          n_fields = 0, n_errs = 0, n_done = 0;
  logic [31:0] q_ftag[$], q_fval[$];
  int          q_flen[$];
  logic [1:0]  q_ecode[$];
  logic [7:0]  q_cks[$];
  logic        q_ok[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (field_valid_o) begin
        n_fields++;
        q_ftag.push_back(field_tag_o);
        q_fval.push_back(field_value_o);
        q_flen.push_back(int'(field_len_o));
      end
      if (error_o) begin
        n_errs++;
        q_ecode.push_back(error_code_o);
      end
      if (msg_done_o) begin
        n_done++;
        q_cks.push_back(checksum_o);
        q_ok.push_back(checksum_ok_o);
      end
    end
  end

  task automatic idle();
    data_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps)
      while ($urandom_range(0, 2) == 0) begin
        data_valid_i = 1'b0;
        data_i = 8'($urandom);
        @(posedge clk); #1;
      end
    data_i = b;
    data_valid_i = 1'b1;
    @(posedge clk); #1;
    data_valid_i = 1'b0;
  endtask

  // '|' in these strings stands for SOH.
  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++)
      send_byte((s[i] == 8'h7C) ? 8'h01 : 8'(s[i]), gaps);
    idle();
  endtask

  task automatic do_reset();
    data_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference model operating on whole fields.
  logic [7:0]  m_msg_sum;
  bit          m_new;
  logic [NW-1:0] m_hit;
  logic [31:0] m_wval[NW];
  logic [31:0] wtag[NW];
  logic [NW-1:0] wen;
  logic [31:0] m_ftag[$], m_fval[$];
  int          m_flen[$];
  logic [1:0]  m_ecode[$];
  logic [7:0]  m_cks[$];
  logic        m_ok[$];

  function automatic bit isdig(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  task automatic model_field(input logic [7:0] f[$]);
    int ndig = 0;
    int vlen;
    int num;
    logic [31:0] tag = 0;
    logic [31:0] val = 0;
    logic [7:0] sum = 0;
    bit ok;
    if (m_new) begin m_hit = '0; m_new = 0; end
    foreach (f[i]) sum += f[i];
    while (isdig(f[ndig])) ndig++;
    for (int i = 0; i < ndig && i < 9; i++) tag = tag * 10 + 32'(f[i] - 8'h30);
    if (ndig >= 10 || ndig == 0 || f[ndig] != 8'h3D) begin
      m_ecode.push_back(2'd1);
    end else begin
      vlen = f.size() - ndig - 2;
      if (vlen > VB) begin
        m_ecode.push_back(2'd2);
      end else begin
        for (int j = 0; j < vlen; j++) val[8*j +: 8] = f[ndig + 1 + j];
        m_ftag.push_back(tag); m_fval.push_back(val); m_flen.push_back(vlen);
        for (int c = 0; c < NW; c++)
          if (wen[c] && wtag[c] == tag) begin m_wval[c] = val; m_hit[c] = 1'b1; end
        if (tag == 10) begin
          ok = (vlen == 3) && isdig(val[7:0]) && isdig(val[15:8]) && isdig(val[23:16]);
          num = 100 * int'(val[7:0] - 8'h30) + 10 * int'(val[15:8] - 8'h30) + int'(val[23:16] - 8'h30);
          m_cks.push_back(m_msg_sum);
          m_ok.push_back(ok && (num == int'(m_msg_sum)));
          m_msg_sum = 0;
          m_new = 1;
        end
      end
    end
    if (tag != 10) m_msg_sum += sum;
  endtask

  task automatic send_field(input string s);
    logic [7:0] f[$];
    for (int i = 0; i < s.len(); i++) f.push_back(8'(s[i]));
    f.push_back(8'h01);
    model_field(f);
    foreach (f[i]) send_byte(f[i], 1'b1);
  endtask

  typedef struct {
    string       s;
    int          nf, ne;
    logic [1:0]  code;
    logic [31:0] tag;
    int          len;
    logic [31:0] val;
    int          nd;
    logic [7:0]  cks;
    logic        ok;
    logic [3:0]  hit;
    logic [31:0] w0;
  } vec_t;

  vec_t vt[6];

  initial begin
    int f0, e0, d0;
    string s;
    int r, kind, vlen, tag;

    rst = 1'b1; data_i = 8'h00; data_valid_i = 1'b0;
    watch_tag_i = '0; watch_en_i = '0;
    vt[0] = '{"35=D|",                      1, 0, 2'd0, 35, 1, 32'h44,       0, 8'h00, 1'b0, 4'b0001, 32'h44};
    vt[1] = '{"35=D|10=234|",               2, 0, 2'd0, 10, 3, 32'h00343332, 1, 8'hEA, 1'b1, 4'b0001, 32'h44};
    vt[2] = '{"35=D|10=233|",               2, 0, 2'd0, 10, 3, 32'h00333332, 1, 8'hEA, 1'b0, 4'b0001, 32'h44};
    vt[3] = '{"58=ABCDE|10=250|",           1, 1, 2'd2, 10, 3, 32'h00303532, 1, 8'hFA, 1'b1, 4'b0000, 32'h0};
    vt[4] = '{"3A=1|=5|1234567890=X|35=D|", 1, 3, 2'd1, 35, 1, 32'h44,       0, 8'h00, 1'b0, 4'b0001, 32'h44};
    vt[5] = '{"58=|",                       1, 0, 2'd0, 58, 0, 32'h0,        0, 8'h00, 1'b0, 4'b0000, 32'h0};

    @(posedge clk); #1;
    chk("rst_field_valid", field_valid_o, 0);
    chk("rst_field_tag", field_tag_o, 0);
    chk("rst_field_value", field_value_o, 0);
    chk("rst_msg_done", {msg_done_o, checksum_ok_o, checksum_o}, 0);
    chk("rst_error", {error_o, error_code_o}, 0);
    chk("rst_watch", {watch_hit_o, watch_value_o}, 0);
    rst = 1'b0;

    watch_tag_i[31:0] = 32'd35;
    watch_en_i = 4'b0001;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      f0 = n_fields; e0 = n_errs; d0 = n_done;
      send_str(vt[v].s, 1'b0);
      chk($sformatf("v%0d_nfields", v), n_fields - f0, vt[v].nf);
      chk($sformatf("v%0d_nerrs", v), n_errs - e0, vt[v].ne);
      chk($sformatf("v%0d_code", v), error_code_o, vt[v].code);
      chk($sformatf("v%0d_tag", v), field_tag_o, vt[v].tag);
      chk($sformatf("v%0d_len", v), field_len_o, vt[v].len);
      chk($sformatf("v%0d_value", v), field_value_o, vt[v].val);
      chk($sformatf("v%0d_ndone", v), n_done - d0, vt[v].nd);
      chk($sformatf("v%0d_checksum", v), checksum_o, vt[v].cks);
      chk($sformatf("v%0d_ck_ok", v), checksum_ok_o, vt[v].ok);
      chk($sformatf("v%0d_hit", v), watch_hit_o, vt[v].hit);
      chk($sformatf("v%0d_w0", v), watch_value_o[31:0], vt[v].w0);
    end

    // First byte of the next message clears hit but keeps the captured value.
    do_reset();
    send_str("35=D|10=234|", 1'b0);
    chk("hit_before_next", watch_hit_o, 4'b0001);
    send_byte(8'h35, 1'b0);
    idle();
    chk("hit_cleared", watch_hit_o, 4'b0000);
    chk("value_kept", watch_value_o[31:0], 32'h44);

    // Gaps in data_valid_i give the same result as the gapless stream.
    do_reset();
    f0 = n_fields; e0 = n_errs;
    send_str("35=D|", 1'b1);
    chk("gap_nfields", n_fields - f0, 1);
    chk("gap_nerrs", n_errs - e0, 0);
    chk("gap_field", {field_tag_o, field_value_o, 29'd0, field_len_o}, {32'd35, 32'h44, 32'd1});

    // Reset mid-field clears outputs and the partial field.
    do_reset();
    send_str("35=D|", 1'b0);
    send_byte(8'h35, 1'b0); send_byte(8'h35, 1'b0); send_byte(8'h3D, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_field", {field_tag_o, field_value_o, 29'd0, field_len_o}, 0);
    chk("midrst_watch", {watch_hit_o, watch_value_o}, 0);
    #2 rst = 1'b0;
    f0 = n_fields; e0 = n_errs;
    send_str("49=X|", 1'b0);
    chk("after_rst_nerrs", n_errs - e0, 0);
    chk("after_rst_nfields", n_fields - f0, 1);
    chk("after_rst_field", {field_tag_o, field_value_o, 29'd0, field_len_o}, {32'd49, 32'h58, 32'd1});

    // Randomized messages against the field-level model.
    do_reset();
    for (int c = 0; c < NW; c++) begin
      wtag[c] = 32'(20 + c * 200 + $urandom_range(0, 150));
      watch_tag_i[32*c +: 32] = wtag[c];
      m_wval[c] = '0;
    end
    wen = 4'($urandom_range(1, 15));
    watch_en_i = wen;
    m_msg_sum = 0; m_new = 1; m_hit = '0;
    q_ftag.delete(); q_fval.delete(); q_flen.delete(); q_ecode.delete(); q_cks.delete(); q_ok.delete();
    for (int m = 0; m < 60; m++) begin
      r = $urandom_range(0, 3);
      for (int k = 0; k < r; k++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          case ($urandom_range(0, 4))
            0: s = "3A=1";
            1: s = "=5";
            2: s = "1234567890=X";
            3: s = "";
            default: s = "77";
          endcase
        end else begin
          tag = (kind < 5) ? int'(wtag[$urandom_range(0, NW-1)]) : $urandom_range(11, 999);
          s = $sformatf("%0d=", tag);
          vlen = $urandom_range(0, VB + 1);
          for (int j = 0; j < vlen; j++) s = {s, string'(8'($urandom_range(33, 126)))};
        end
        send_field(s);
      end
      case ($urandom_range(0, 5))
        0: s = $sformatf("10=%03d", (int'(m_msg_sum) + 1) % 256);
        1: s = $sformatf("10=%02d", int'(m_msg_sum) % 100);
        default: s = $sformatf("10=%03d", int'(m_msg_sum));
      endcase
      send_field(s);
      idle();
      chk($sformatf("rnd%0d_hit", m), watch_hit_o, m_hit);
      for (int c = 0; c < NW; c++)
        chk($sformatf("rnd%0d_wval%0d", m, c), watch_value_o[c*32 +: 32], m_wval[c]);
    end
    idle();
    chk("rnd_nfields", q_ftag.size(), m_ftag.size());
    for (int i = 0; i < q_ftag.size() && i < m_ftag.size(); i++) begin
      chk($sformatf("rnd_ftag%0d", i), q_ftag[i], m_ftag[i]);
      chk($sformatf("rnd_fval%0d", i), q_fval[i], m_fval[i]);
      chk($sformatf("rnd_flen%0d", i), q_flen[i], m_flen[i]);
    end
    chk("rnd_nerrs", q_ecode.size(), m_ecode.size());
    for (int i = 0; i < q_ecode.size() && i < m_ecode.size(); i++)
      chk($sformatf("rnd_ecode%0d", i), q_ecode[i], m_ecode[i]);
    chk("rnd_ndone", q_cks.size(), m_cks.size());
    for (int i = 0; i < q_cks.size() && i < m_cks.size(); i++) begin
      chk($sformatf("rnd_cks%0d", i), q_cks[i], m_cks[i]);
      chk($sformatf("rnd_ok%0d", i), q_ok[i], m_ok[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
